// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-buffered 8N1 UART transmitter with a cycle-count baud divider.
module uart_transmitter #(
  parameter int P_BAUD_DIV     = 434,
  parameter int P_FIFO_DEPTH   = 16,
  parameter int P_FIFO_DEPTH_N = 4
) (
  input  logic                      iCLOCK,
  input  logic                      inRESET,
  input  logic                      iTX_REQ,
  input  logic [7:0]                iTX_DATA,
  output logic                      oTX_FULL,
  output logic                      oTX_EMPTY,
  output logic [P_FIFO_DEPTH_N:0]   oTX_COUNT,
  output logic                      oTX_BUSY,
  output logic                      oUART_TXD
);
  localparam int CW = P_FIFO_DEPTH_N + 1;
  localparam logic [15:0] BAUD_LAST = 16'(P_BAUD_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                    state_q, state_d;
  logic [15:0]               baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [7:0]                shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic [P_FIFO_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [7:0]                mem_q [P_FIFO_DEPTH];
  logic                      push, pop, bit_end;
  assign oTX_FULL  = count_q == CW'(P_FIFO_DEPTH);
  assign oTX_EMPTY = count_q == '0;
  assign oTX_COUNT = count_q;
  assign oTX_BUSY  = state_q != IDLE;
  assign oUART_TXD = txd_q;
  assign bit_end   = baud_q == 16'd0;
  // A full FIFO drops the write even when a pop frees a slot on the same edge.
  assign push      = iTX_REQ && !oTX_FULL;
  assign pop       = !oTX_EMPTY && (state_q == IDLE || (state_q == STOP && bit_end));
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q - 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    wr_ptr_d = push ? wr_ptr_q + P_FIFO_DEPTH_N'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + P_FIFO_DEPTH_N'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    unique case (state_q)
      IDLE: begin
        baud_d = BAUD_LAST;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: if (bit_end) begin
        baud_d  = BAUD_LAST;
        bit_d   = 3'd0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        baud_d  = BAUD_LAST;
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        baud_d  = BAUD_LAST;
        shift_d = pop ? mem_q[rd_ptr_q] : shift_q;
        state_d = pop ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // TXD is registered from the next state so the line changes on the same edge as the FSM.
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge iCLOCK) begin
    if (push) mem_q[wr_ptr_q] <= iTX_DATA;
  end
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_q  <= IDLE;
      baud_q   <= BAUD_LAST;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed stimulus with a queue-based frame model checked every cycle.
module tb_uart_transmitter;
  localparam int DIV = 4;
  localparam int DEPTH = 16;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       full, empty, busy, txd;
  logic [4:0] count;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] fifo_m [$];
  logic       wave_m [$];
  bit         valid = 1'b0;
  int         pre;
  logic [7:0] hb;

  uart_transmitter #(.P_BAUD_DIV(DIV), .P_FIFO_DEPTH(DEPTH), .P_FIFO_DEPTH_N(4)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iTX_REQ(tx_req), .iTX_DATA(tx_data),
    .oTX_FULL(full), .oTX_EMPTY(empty), .oTX_COUNT(count), .oTX_BUSY(busy), .oUART_TXD(txd)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a frame is a list of line levels, one per cycle; a new frame is loaded when the previous one runs out.
  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_m.delete();
      wave_m.delete();
      valid = 1'b1;
    end else begin
      pre = fifo_m.size();
      if (wave_m.size() > 0) void'(wave_m.pop_front());
      if (wave_m.size() == 0 && pre > 0) begin
        hb = fifo_m.pop_front();
        for (int i = 0; i < 10 * DIV; i++)
          wave_m.push_back(i < DIV ? 1'b0 : i >= 9 * DIV ? 1'b1 : hb[i / DIV - 1]);
      end
      if (tx_req && pre < DEPTH) fifo_m.push_back(tx_data);
    end
  end

  always @(negedge clk) if (valid) begin
    chk("m_txd", txd, wave_m.size() > 0 ? wave_m[0] : 1'b1);
    chk("m_busy", busy, wave_m.size() > 0);
    chk("m_count", count, fifo_m.size());
    chk("m_empty", empty, fifo_m.size() == 0);
    chk("m_full", full, fifo_m.size() == DEPTH);
  end

  task automatic wr(input logic [7:0] b);
    tx_data = b;
    tx_req = 1'b1;
    @(posedge clk);
    #1 tx_req = 1'b0;
  endtask

  task automatic send_check(input logic [7:0] b, input logic [9:0] pat);
    wr(b);
    @(negedge clk);
    chk("lit_pre_txd", txd, 1);
    chk("lit_pre_count", count, 1);
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge clk);
      chk("lit_frame_txd", txd, pat[k / DIV]);
      chk("lit_frame_busy", busy, 1);
    end
    @(negedge clk);
    chk("lit_post_busy", busy, 0);
    chk("lit_post_txd", txd, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || !empty) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", busy || !empty, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("lit_idle_txd", txd, 1);
      chk("lit_idle_busy", busy, 0);
      chk("lit_idle_empty", empty, 1);
      chk("lit_idle_count", count, 0);
    end
    @(posedge clk);
    #1 send_check(8'h55, 10'b1010101010);
    @(posedge clk);
    #1;
    for (int i = 0; i <= 16; i++) begin
      tx_data = 8'(i);
      tx_req = 1'b1;
      @(posedge clk);
      #1;
    end
    tx_data = 8'hEE;
    @(negedge clk);
    chk("lit_burst_count", count, 16);
    chk("lit_burst_full", full, 1);
    repeat (25) @(posedge clk);
    #1 tx_req = 1'b0;
    @(negedge clk);
    chk("lit_stop_drop_count", count, 15);
    chk("lit_stop_drop_full", full, 0);
    drain();
    @(posedge clk);
    #1 wr(8'h3C);
    wr(8'h99);
    repeat (17) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("lit_midframe_busy", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_txd", txd, 1);
    chk("lit_rst_count", count, 0);
    chk("lit_rst_busy", busy, 0);
    @(posedge clk);
    #1 send_check(8'hA5, 10'b1101001010);
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
